// File: rtl/inst_fetch_sb.sv
// Instruction-fetch stage: issues one instruction per cycle to decode and inserts bubbles
// for RAW hazards (tracked in a small destination scoreboard), unresolved branches and HALT.
module inst_fetch_sb #(
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 2,
    parameter int FWD_EN   = 0,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              id_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              halted,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  br_cnt
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT_BR,
        HALT_S
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nx;

    // Scoreboard, entry 0 is the most recently issued slot
    logic [SB_DEPTH-1:0] sb_valid;
    logic [SB_DEPTH-1:0] sb_load;
    logic [4:0]          sb_dest [SB_DEPTH];

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       reads_rs;
    logic       reads_rt;
    logic       writes;
    logic [4:0] dest;
    logic       dec_load;
    logic       dec_branch;
    logic       dec_halt;
    logic       hazard;
    logic       issue;
    logic       stall_inc;
    logic       br_inc;

    assign opcode = imem_rdata[31:26];
    assign rs     = imem_rdata[25:21];
    assign rt     = imem_rdata[20:16];
    assign rd     = imem_rdata[15:11];

    always_comb begin
        reads_rs   = 1'b0;
        reads_rt   = 1'b0;
        writes     = 1'b0;
        dest       = rt;
        dec_load   = 1'b0;
        dec_branch = 1'b0;
        dec_halt   = 1'b0;
        case (opcode)
            6'h00, 6'h02, 6'h04, 6'h06, 6'h08, 6'h0A: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                writes   = 1'b1;
                dest     = rd;
            end
            6'h01, 6'h03, 6'h05, 6'h07, 6'h09, 6'h0B: begin
                reads_rs = 1'b1;
                writes   = 1'b1;
            end
            6'h0C: begin
                reads_rs = 1'b1;
                writes   = 1'b1;
                dec_load = 1'b1;
            end
            6'h0D: begin
                reads_rs = 1'b1;
                reads_rt = 1'b1;
            end
            6'h0F: begin
                reads_rs   = 1'b1;
                reads_rt   = 1'b1;
                dec_branch = 1'b1;
            end
            6'h0E, 6'h10: begin
                reads_rs   = 1'b1;
                dec_branch = 1'b1;
            end
            6'h11: dec_halt = 1'b1;
            default: ;
        endcase
    end

    // With forwarding only a load still in flight directly ahead can stall
    always_comb begin
        hazard = 1'b0;
        if (FWD_EN != 0) begin
            if (sb_valid[0] && sb_load[0] &&
                ((reads_rs && sb_dest[0] == rs) || (reads_rt && sb_dest[0] == rt)))
                hazard = 1'b1;
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                if (sb_valid[i] &&
                    ((reads_rs && sb_dest[i] == rs) || (reads_rt && sb_dest[i] == rt)))
                    hazard = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        inst_valid = 1'b0;
        issue      = 1'b0;
        stall_inc  = 1'b0;
        br_inc     = 1'b0;
        case (state)
            FETCH: begin
                inst_valid = !hazard && !rst;
                issue      = inst_valid && id_ready;
                stall_inc  = hazard && id_ready;
                if (issue) begin
                    pc_nx = pc + ADDR_W'(4);
                    if (dec_branch)
                        state_nx = WAIT_BR;
                    else if (dec_halt)
                        state_nx = HALT_S;
                end
            end
            WAIT_BR: begin
                // A resolved redirect is taken even while decode is stalled
                if (redirect_valid) begin
                    pc_nx    = redirect_addr;
                    state_nx = FETCH;
                end else begin
                    br_inc = id_ready;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            sb_load  <= '0;
            for (int i = 0; i < SB_DEPTH; i++)
                sb_dest[i] <= '0;
        end else if (id_ready) begin
            for (int i = SB_DEPTH - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_load[i]  <= sb_load[i-1];
                sb_dest[i]  <= sb_dest[i-1];
            end
            sb_valid[0] <= issue && writes;
            sb_load[0]  <= issue && dec_load;
            sb_dest[0]  <= dest;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            br_cnt    <= '0;
        end else begin
            if (stall_inc && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_inc && br_cnt != '1)
                br_cnt <= br_cnt + CNT_W'(1);
        end
    end

    assign imem_addr = pc;
    assign inst      = imem_rdata;
    assign inst_pc   = pc;
    assign halted    = (state == HALT_S);

endmodule

// File: tb/tb_inst_fetch_sb.sv
// Directed bench for inst_fetch_sb: one no-forwarding instance, one forwarding instance
// and one narrow-counter deeper-scoreboard instance, each fed from its own small program ROM.
module tb_inst_fetch_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Instance 0: FWD_EN=0, SB_DEPTH=2, CNT_W=32
    logic        rst;
    logic        id_ready;
    logic        redir_v;
    logic [31:0] redir_a;
    logic [31:0] a0, rdata0, inst0, ipc0, s0, b0;
    logic        v0, h0;
    logic [31:0] mem0 [64];

    // Instances 1 and 2 share a reset and never see backpressure or redirects
    logic        rst12;
    logic        one;
    logic        zero;
    logic [31:0] zaddr;
    logic [31:0] a1, rdata1, inst1, ipc1, s1, b1;
    logic        v1, h1;
    logic [31:0] mem1 [64];
    logic [31:0] a2, rdata2, inst2, ipc2;
    logic [1:0]  s2, b2;
    logic        v2, h2;
    logic [31:0] mem2 [64];

    assign rdata0 = mem0[a0[7:2]];
    assign rdata1 = mem1[a1[7:2]];
    assign rdata2 = mem2[a2[7:2]];

    inst_fetch_sb #(.ADDR_W(32), .SB_DEPTH(2), .FWD_EN(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst), .imem_addr(a0), .imem_rdata(rdata0), .inst(inst0),
        .inst_pc(ipc0), .inst_valid(v0), .id_ready(id_ready), .redirect_valid(redir_v),
        .redirect_addr(redir_a), .halted(h0), .stall_cnt(s0), .br_cnt(b0)
    );

    inst_fetch_sb #(.ADDR_W(32), .SB_DEPTH(2), .FWD_EN(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst12), .imem_addr(a1), .imem_rdata(rdata1), .inst(inst1),
        .inst_pc(ipc1), .inst_valid(v1), .id_ready(one), .redirect_valid(zero),
        .redirect_addr(zaddr), .halted(h1), .stall_cnt(s1), .br_cnt(b1)
    );

    inst_fetch_sb #(.ADDR_W(32), .SB_DEPTH(3), .FWD_EN(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst12), .imem_addr(a2), .imem_rdata(rdata2), .inst(inst2),
        .inst_pc(ipc2), .inst_valid(v2), .id_ready(one), .redirect_valid(zero),
        .redirect_addr(zaddr), .halted(h2), .stall_cnt(s2), .br_cnt(b2)
    );

    function automatic logic [31:0] r_op(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rsrc, input logic [4:0] tsrc);
        return {op, rsrc, tsrc, rd, 11'd0};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] tdst,
                                         input logic [4:0] rsrc);
        return {op, rsrc, tdst, 16'd0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] ra);
        rst      = r;
        id_ready = rdy;
        redir_v  = rv;
        redir_a  = ra;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] halt_w;
        halt_w = {6'h11, 26'd0};
        one    = 1'b1;
        zero   = 1'b0;
        zaddr  = '0;
        rst12  = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 64; i++) begin
            mem0[i] = {6'h3F, 26'd0};
            mem1[i] = {6'h3F, 26'd0};
            mem2[i] = {6'h3F, 26'd0};
        end
        mem0[0]  = r_op(6'h00, 5'd3, 5'd1, 5'd2);
        mem0[1]  = r_op(6'h00, 5'd4, 5'd3, 5'd1);
        mem0[2]  = r_op(6'h0F, 5'd0, 5'd10, 5'd11);
        mem0[4]  = halt_w;
        mem0[16] = r_op(6'h00, 5'd8, 5'd1, 5'd2);
        mem0[17] = r_op(6'h00, 5'd7, 5'd1, 5'd2);
        mem0[18] = r_op(6'h00, 5'd9, 5'd8, 5'd1);
        mem0[19] = r_op(6'h00, 5'd5, 5'd1, 5'd2);
        mem0[20] = r_op(6'h00, 5'd6, 5'd5, 5'd5);
        mem0[21] = r_op(6'h10, 5'd0, 5'd31, 5'd0);

        mem1[0] = r_op(6'h00, 5'd3, 5'd1, 5'd2);
        mem1[1] = r_op(6'h00, 5'd4, 5'd3, 5'd1);
        mem1[2] = i_op(6'h0C, 5'd5, 5'd1);
        mem1[3] = r_op(6'h00, 5'd6, 5'd5, 5'd1);
        mem1[4] = r_op(6'h00, 5'd7, 5'd5, 5'd1);
        mem1[5] = halt_w;

        mem2[0] = r_op(6'h00, 5'd3, 5'd1, 5'd2);
        mem2[1] = r_op(6'h00, 5'd4, 5'd3, 5'd1);
        mem2[2] = r_op(6'h00, 5'd5, 5'd4, 5'd1);

        // Reset held for three cycles
        repeat (3) @(negedge clk);
        checkOutput("rst_addr", a0, 32'h0);
        checkOutput("rst_valid", 32'(v0), 32'd0);
        checkOutput("rst_stall", s0, 32'd0);
        checkOutput("rst_br", b0, 32'd0);
        checkOutput("rst_halted", 32'(h0), 32'd0);
        checkOutput("rst_pc", ipc0, 32'h0);

        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("c0_valid", 32'(v0), 32'd1);
        checkOutput("c0_addr", a0, 32'h0);
        checkOutput("c0_inst", inst0, mem0[0]);

        // Adjacent RAW without forwarding: two bubbles
        @(negedge clk);
        checkOutput("c1_addr", a0, 32'h4);
        checkOutput("c1_valid", 32'(v0), 32'd0);
        checkOutput("c1_stall", s0, 32'd0);
        @(negedge clk);
        checkOutput("c2_valid", 32'(v0), 32'd0);
        checkOutput("c2_stall", s0, 32'd1);
        @(negedge clk);
        checkOutput("c3_valid", 32'(v0), 32'd1);
        checkOutput("c3_pc", ipc0, 32'h4);
        checkOutput("c3_stall", s0, 32'd2);

        // BEQ issues, then waits for EX
        @(negedge clk);
        checkOutput("c4_addr", a0, 32'h8);
        checkOutput("c4_valid", 32'(v0), 32'd1);
        @(negedge clk);
        checkOutput("c5_addr", a0, 32'hC);
        checkOutput("c5_valid", 32'(v0), 32'd0);
        checkOutput("c5_br", b0, 32'd0);
        @(negedge clk);
        checkOutput("c6_valid", 32'(v0), 32'd0);
        checkOutput("c6_br", b0, 32'd1);
        @(negedge clk);
        checkOutput("c7_valid", 32'(v0), 32'd0);
        checkOutput("c7_br", b0, 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);

        // Redirect lands; a redirect pulse in FETCH must be ignored
        @(negedge clk);
        checkOutput("c8_addr", a0, 32'h40);
        checkOutput("c8_valid", 32'(v0), 32'd1);
        checkOutput("c8_br", b0, 32'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("c9_spurious_addr", a0, 32'h44);
        checkOutput("c9_unrelated_valid", 32'(v0), 32'd1);

        // RAW at distance 2: one bubble
        @(negedge clk);
        checkOutput("c10_addr", a0, 32'h48);
        checkOutput("c10_valid", 32'(v0), 32'd0);
        checkOutput("c10_stall", s0, 32'd2);
        @(negedge clk);
        checkOutput("c11_valid", 32'(v0), 32'd1);
        checkOutput("c11_stall", s0, 32'd3);
        @(negedge clk);
        checkOutput("c12_addr", a0, 32'h4C);
        checkOutput("c12_valid", 32'(v0), 32'd1);

        // Adjacent RAW with four cycles of backpressure in the middle
        @(negedge clk);
        checkOutput("c13_addr", a0, 32'h50);
        checkOutput("c13_valid", 32'(v0), 32'd0);
        checkOutput("c13_stall", s0, 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bp_addr", a0, 32'h50);
            checkOutput("bp_valid", 32'(v0), 32'd0);
            checkOutput("bp_stall", s0, 32'd3);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("c18_valid", 32'(v0), 32'd0);
        checkOutput("c18_stall", s0, 32'd4);
        @(negedge clk);
        checkOutput("c19_valid", 32'(v0), 32'd1);
        checkOutput("c19_addr", a0, 32'h50);
        checkOutput("c19_stall", s0, 32'd5);

        // JR, then a redirect accepted while decode is stalled
        @(negedge clk);
        checkOutput("c20_addr", a0, 32'h54);
        checkOutput("c20_valid", 32'(v0), 32'd1);
        @(negedge clk);
        checkOutput("c21_valid", 32'(v0), 32'd0);
        checkOutput("c21_addr", a0, 32'h58);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("c22_addr", a0, 32'h10);
        checkOutput("c22_br", b0, 32'd2);
        checkOutput("c22_valid", 32'(v0), 32'd1);
        checkOutput("c22_inst", inst0, halt_w);

        // HALT: frozen for 20 cycles, redirect ignored
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) applyStimulus(1'b0, 1'b1, 1'b1, 32'h80);
            if (i == 6) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkOutput("halt_flag", 32'(h0), 32'd1);
            checkOutput("halt_valid", 32'(v0), 32'd0);
            checkOutput("halt_addr", a0, 32'h14);
        end
        checkOutput("halt_br", b0, 32'd2);
        checkOutput("halt_stall", s0, 32'd5);

        // Asynchronous reset mid-operation, then restart from 0
        #2;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("arst_addr", a0, 32'h0);
        checkOutput("arst_halted", 32'(h0), 32'd0);
        checkOutput("arst_stall", s0, 32'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("rs0_valid", 32'(v0), 32'd1);
        checkOutput("rs0_addr", a0, 32'h0);
        @(negedge clk);
        checkOutput("rs1_addr", a0, 32'h4);

        // Forwarding instance and saturating narrow-counter instance
        @(negedge clk);
        rst12 = 1'b0;
        #1;
        checkOutput("f0_valid", 32'(v1), 32'd1);
        checkOutput("s0_valid", 32'(v2), 32'd1);
        @(negedge clk);
        checkOutput("f1_addr", a1, 32'h4);
        checkOutput("f1_valid", 32'(v1), 32'd1);
        checkOutput("s1_addr", a2, 32'h4);
        checkOutput("s1_valid", 32'(v2), 32'd0);
        @(negedge clk);
        checkOutput("f2_addr", a1, 32'h8);
        checkOutput("f2_valid", 32'(v1), 32'd1);
        checkOutput("s2_valid", 32'(v2), 32'd0);
        checkOutput("s2_stall", 32'(s2), 32'd1);
        @(negedge clk);
        checkOutput("f3_addr", a1, 32'hC);
        checkOutput("f3_valid", 32'(v1), 32'd0);
        checkOutput("f3_stall", s1, 32'd0);
        checkOutput("s3_valid", 32'(v2), 32'd0);
        checkOutput("s3_stall", 32'(s2), 32'd2);
        @(negedge clk);
        checkOutput("f4_addr", a1, 32'hC);
        checkOutput("f4_valid", 32'(v1), 32'd1);
        checkOutput("f4_stall", s1, 32'd1);
        checkOutput("s4_valid", 32'(v2), 32'd1);
        checkOutput("s4_addr", a2, 32'h4);
        checkOutput("s4_stall", 32'(s2), 32'd3);
        @(negedge clk);
        checkOutput("f5_addr", a1, 32'h10);
        checkOutput("f5_valid", 32'(v1), 32'd1);
        checkOutput("f5_stall", s1, 32'd1);
        checkOutput("s5_addr", a2, 32'h8);
        checkOutput("s5_valid", 32'(v2), 32'd0);
        checkOutput("s5_stall", 32'(s2), 32'd3);
        @(negedge clk);
        checkOutput("f6_addr", a1, 32'h14);
        checkOutput("f6_valid", 32'(v1), 32'd1);
        checkOutput("s6_valid", 32'(v2), 32'd0);
        checkOutput("s6_stall", 32'(s2), 32'd3);
        @(negedge clk);
        checkOutput("f7_halted", 32'(h1), 32'd1);
        checkOutput("f7_valid", 32'(v1), 32'd0);
        checkOutput("s7_valid", 32'(v2), 32'd0);
        checkOutput("s7_stall", 32'(s2), 32'd3);
        @(negedge clk);
        checkOutput("s8_valid", 32'(v2), 32'd1);
        checkOutput("s8_addr", a2, 32'h8);
        checkOutput("s8_stall", 32'(s2), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_sb.md
# inst_fetch_sb

Parametrised instruction-fetch stage with an in-flight destination scoreboard, selectable forwarding mode, branch-wait and halt handling, and saturating stall statistics. It sits between the external instruction memory and the decode stage. It issues one instruction per cycle to decode over a valid/ready handshake. It inserts bubbles itself on RAW hazards and on unresolved control flow.

## Interface
- ADDR_W, 32: PC / memory byte-address width.
- SB_DEPTH, 2: number of previously issued slots tracked for hazards (1..4).
- FWD_EN, 0: 0 stalls on any RAW match in the scoreboard; 1 stalls only on load-use.
- CNT_W, 32: statistics counter width.

- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  ADDR_W  byte address of the current fetch (PC).
- imem_rdata  in  32  instruction at imem_addr, combinational read, same cycle.
- inst  out  32  instruction presented to decode, equals imem_rdata.
- inst_pc  out  ADDR_W  PC of inst.
- inst_valid  out  1  inst is issued this cycle when id_ready=1.
- id_ready  in  1  decode accepts. 0 freezes the whole stage.
- redirect_valid  in  1  EX resolved a control instruction. Single-cycle pulse.
- redirect_addr  in  ADDR_W  next PC from EX: target if taken, else pc+4.
- halted  out  1  HALT has been issued.
- stall_cnt  out  CNT_W  data-hazard bubble cycles, saturating.
- br_cnt  out  CNT_W  branch-wait cycles, saturating.

## Operation
- Opcode is inst[31:26].
  - R-type ALU ops are 0x00, 0x02, 0x04, 0x06, 0x08, 0x0A. They read rs [25:21] and rt [20:16] and write rd [15:11].
  - I-type ALU ops are 0x01, 0x03, 0x05, 0x07, 0x09, 0x0B. LDW is 0x0C. These read rs and write rt.
  - STW is 0x0D: reads rs, rt; no write.
  - BEQ is 0x0F: reads rs, rt.
  - BZ is 0x0E and JR is 0x10: read rs.
  - HALT is 0x11. NOP is 0x3F. NOP and all other opcodes read and write nothing.
  - R0 is not special.
- Scoreboard: SB_DEPTH entries {valid, dest[4:0], is_load}. Entry 0 is the most recently issued slot.
  - It shifts only when id_ready=1.
  - An issued writer shifts in {1, dest, opcode==0x0C}. An issued non-writer or a bubble shifts in {0, -, 0}.
- Hazard:
  - FWD_EN=0: any valid entry whose dest equals any source of inst.
  - FWD_EN=1: only entry 0 with is_load=1 matching a source.
- States:
  - FETCH (after reset):
    - inst_valid = !hazard.
    - On issue (inst_valid & id_ready): PC += 4.
    - An issued BZ/BEQ/JR moves to WAIT_BR. An issued HALT moves to HALT_S and sets halted.
    - On a hazard: PC is held and a bubble is shifted in.
  - WAIT_BR:
    - inst_valid=0 and PC is held; bubbles shift in.
    - On redirect_valid: PC <= redirect_addr and return to FETCH. This applies even if id_ready=0.
  - HALT_S:
    - inst_valid=0, PC frozen at the HALT address + 4, redirect ignored.
    - Exits only on rst.
- redirect_valid is ignored in FETCH and HALT_S.
- id_ready=0 freezes PC, scoreboard, state and counters. The only exception is a redirect accepted in WAIT_BR.
- Counters:
  - stall_cnt +1 per cycle with FETCH & hazard & id_ready.
  - br_cnt +1 per cycle in WAIT_BR with no redirect_valid.
  - Both hold at 2^CNT_W-1.

## Timing
- Reset values: imem_addr=0, inst_pc=0, inst_valid=0, halted=0, stall_cnt=0, br_cnt=0, scoreboard all invalid, state FETCH.
- Reset asserted mid-operation clears all state immediately, without waiting for an edge.
- The first issue is the first cycle after rst deasserts, with the instruction at address 0.
- Issue to next PC: 1 edge. Throughput is 1 instruction/cycle with no hazards.
- Branch issued at edge E: WAIT_BR from E.
  - A redirect in cycle N gives imem_addr=redirect_addr in cycle N+1, and its instruction is issuable that cycle.
  - Minimum branch penalty is the cycles until EX pulses.
- RAW distance d (1 = adjacent), FWD_EN=0: bubbles = SB_DEPTH-d+1 when d ≤ SB_DEPTH, else 0.
- RAW, FWD_EN=1: load-use adjacent gives 1 bubble; all else 0.
- Redirect and rst together: rst wins.

## Test plan
- Reset: hold rst=1 for 3 cycles → imem_addr=0, inst_valid=0, counters 0. Release → the instruction at 0x0 issues in cycle 1 and imem_addr=0x4 in cycle 2.
- FWD_EN=0, SB_DEPTH=2: add r3,r1,r2 at 0x0, then add r4,r3,r1 at 0x4 → 2 bubbles, second add issued 3 cycles after first, stall_cnt=2. Unrelated add r7,r1,r2 → 0 bubbles.
- FWD_EN=1: the same add pair → 0 bubbles. LDW r5 then add r6,r5,r1 → exactly 1 bubble, stall_cnt=1.
- BEQ at 0x8; redirect_valid with 0x40 three cycles after issue → 0xC never issued, br_cnt=2, imem_addr=0x40 the cycle after the pulse. A spurious redirect in FETCH → no effect.
- Hazard with id_ready=0 for 4 cycles → imem_addr, scoreboard and stall_cnt frozen. After id_ready=1 the bubble count is identical to the no-backpressure run.
- HALT at 0x10 → issued once, halted=1 next cycle, inst_valid=0 and imem_addr=0x14 for 20 cycles, redirect ignored. rst → restart from 0x0. With CNT_W=2, forced stalls → stall_cnt saturates at 3.
